// File: rtl/rv_pkg.sv
// Shared types and sizing for the retirement stage and arch map table.
package rv_pkg;

  localparam int N_WAY    = 3;
  localparam int N_ROB    = 32;
  localparam int PRF_SIZE = N_ROB + 32;
  localparam int CDB_BITS = $clog2(PRF_SIZE);
  localparam int RN_W     = $clog2(N_WAY) + 1;
  localparam int N_AREG   = 32;

  typedef logic [CDB_BITS-1:0] phys_tag_t;
  typedef logic [4:0]          arch_reg_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FLUSH  = 2'd1,
    HALTED = 2'd2
  } retire_state_e;

endpackage

// File: rtl/retire_arch_map_select.sv
// Retirable-prefix selection: longest valid+complete run from the oldest slot,
// cut just after the first mispredict or halt (that slot still retires).
module retire_arch_map_select
  import rv_pkg::*;
(
  input  logic [N_WAY-1:0] valid,
  input  logic [N_WAY-1:0] complete,
  input  logic [N_WAY-1:0] mispredict,
  input  logic [N_WAY-1:0] halt,
  output logic [RN_W-1:0]  count,
  output logic [N_WAY-1:0] mask,
  output logic             ends_mispredict,
  output logic             ends_halt
);

  logic stop;

  always_comb begin
    count           = '0;
    mask            = '0;
    ends_mispredict = 1'b0;
    ends_halt       = 1'b0;
    stop            = 1'b0;
    for (int k = 0; k < N_WAY; k++) begin
      if (!stop && valid[k] && complete[k]) begin
        mask[k] = 1'b1;
        count   = count + 1'b1;
        // A slot flagged both ways is treated as a halt.
        if (halt[k]) begin
          ends_halt = 1'b1;
          stop      = 1'b1;
        end else if (mispredict[k]) begin
          ends_mispredict = 1'b1;
          stop            = 1'b1;
        end
      end else begin
        stop = 1'b1;
      end
    end
  end

endmodule

// File: rtl/retire_arch_map.sv
// In-order retirement stage with architectural RAT, freed-tag return,
// mispredict flush pulse and sticky halt.
module retire_arch_map
  import rv_pkg::*;
(
  input  logic                        clock,
  input  logic                        reset,
  input  logic      [N_WAY-1:0]       head_valid,
  input  logic      [N_WAY-1:0]       head_complete,
  input  phys_tag_t [N_WAY-1:0]       head_T,
  input  phys_tag_t [N_WAY-1:0]       head_Told,
  input  arch_reg_t [N_WAY-1:0]       head_areg,
  input  logic      [N_WAY-1:0]       head_mispredict,
  input  logic      [N_WAY-1:0]       head_halt,
  output logic      [RN_W-1:0]        retire_num,
  output phys_tag_t [N_WAY-1:0]       rob_told,
  output logic                        flush,
  output phys_tag_t [N_AREG-1:0]      arch_map,
  output logic                        halted
);

  retire_state_e state, state_next;

  logic [RN_W-1:0]  sel_count;
  logic [N_WAY-1:0] sel_mask;
  logic             sel_mispredict;
  logic             sel_halt;
  logic [N_WAY-1:0] ret_mask;
  phys_tag_t [N_WAY-1:0] told_next;
  logic [$clog2(N_WAY)-1:0] told_idx;

  retire_arch_map_select u_select (
    .valid           (head_valid),
    .complete        (head_complete),
    .mispredict      (head_mispredict),
    .halt            (head_halt),
    .count           (sel_count),
    .mask            (sel_mask),
    .ends_mispredict (sel_mispredict),
    .ends_halt       (sel_halt)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= RUN;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      RUN: begin
        if (sel_halt)            state_next = HALTED;
        else if (sel_mispredict) state_next = FLUSH;
      end
      FLUSH:   state_next = RUN;
      HALTED:  state_next = HALTED;
      default: state_next = RUN;
    endcase
  end

  always_comb begin
    retire_num = (state == RUN) ? sel_count : '0;
    ret_mask   = (state == RUN) ? sel_mask  : '0;
    flush      = (state == FLUSH);
    halted     = (state == HALTED);
  end

  // Compact the nonzero Told tags of retiring slots toward lane 0.
  always_comb begin
    told_next = '0;
    told_idx  = '0;
    for (int k = 0; k < N_WAY; k++) begin
      if (ret_mask[k] && head_Told[k] != '0) begin
        told_next[told_idx] = head_Told[k];
        told_idx            = told_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) rob_told <= '0;
    else       rob_told <= told_next;
  end

  // Slots are applied oldest first so the youngest writer of an areg wins.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_AREG; i++) arch_map[i] <= phys_tag_t'(i);
    end else begin
      for (int k = 0; k < N_WAY; k++) begin
        if (ret_mask[k] && head_T[k] != '0 && head_areg[k] != '0)
          arch_map[head_areg[k]] <= head_T[k];
      end
    end
  end

endmodule

// File: tb/tb_retire_arch_map.sv
// Directed-vector bench for retire_arch_map with hand-computed expectations.
module tb_retire_arch_map;
  import rv_pkg::*;

  logic                   clock = 1'b0;
  logic                   reset;
  logic      [N_WAY-1:0]  head_valid, head_complete, head_mispredict, head_halt;
  phys_tag_t [N_WAY-1:0]  head_T, head_Told;
  arch_reg_t [N_WAY-1:0]  head_areg;
  logic      [RN_W-1:0]   retire_num;
  phys_tag_t [N_WAY-1:0]  rob_told;
  logic                   flush, halted;
  phys_tag_t [N_AREG-1:0] arch_map;

  int n_vec = 0;
  int n_bad = 0;

  retire_arch_map dut (
    .clock           (clock),
    .reset           (reset),
    .head_valid      (head_valid),
    .head_complete   (head_complete),
    .head_T          (head_T),
    .head_Told       (head_Told),
    .head_areg       (head_areg),
    .head_mispredict (head_mispredict),
    .head_halt       (head_halt),
    .retire_num      (retire_num),
    .rob_told        (rob_told),
    .flush           (flush),
    .arch_map        (arch_map),
    .halted          (halted)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_in();
    head_valid = '0; head_complete = '0; head_mispredict = '0; head_halt = '0;
    head_T = '0; head_Told = '0; head_areg = '0;
  endtask

  task automatic set_slot(input int k, input logic c, input int areg, input int t, input int told);
    head_valid[k]    = 1'b1;
    head_complete[k] = c;
    head_areg[k]     = arch_reg_t'(areg);
    head_T[k]        = phys_tag_t'(t);
    head_Told[k]     = phys_tag_t'(told);
  endtask

  task automatic chk_told(input string tag, input int t0, input int t1, input int t2);
    chk({tag, "_told0"}, 32'(rob_told[0]), t0);
    chk({tag, "_told1"}, 32'(rob_told[1]), t1);
    chk({tag, "_told2"}, 32'(rob_told[2]), t2);
  endtask

  initial begin
    clear_in();
    reset = 1'b1;
    #1;
    chk("rst_map5", 32'(arch_map[5]), 5);
    chk("rst_map0", 32'(arch_map[0]), 0);
    step(); step();
    reset = 1'b0;
    #1;
    chk("rst_flush", 32'(flush), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_rnum", 32'(retire_num), 0);
    chk_told("rst", 0, 0, 0);

    // Full-width retirement
    set_slot(0, 1, 1, 40, 1); set_slot(1, 1, 2, 41, 2); set_slot(2, 1, 3, 42, 3);
    #1 chk("full_rnum", 32'(retire_num), 3);
    step(); clear_in();
    chk_told("full", 1, 2, 3);
    chk("full_map1", 32'(arch_map[1]), 40);
    chk("full_map2", 32'(arch_map[2]), 41);
    chk("full_map3", 32'(arch_map[3]), 42);
    #1 chk("idle_rnum", 32'(retire_num), 0);
    step();
    chk_told("idle", 0, 0, 0);

    // Oldest slot incomplete blocks the younger complete ones
    set_slot(0, 0, 4, 43, 4); set_slot(1, 1, 5, 44, 5); set_slot(2, 1, 6, 45, 6);
    #1 chk("gap_rnum", 32'(retire_num), 0);
    step();
    chk_told("gap", 0, 0, 0);
    chk("gap_map5", 32'(arch_map[5]), 5);
    head_complete[0] = 1'b1;
    #1 chk("ungap_rnum", 32'(retire_num), 3);
    step(); clear_in();
    chk_told("ungap", 4, 5, 6);
    chk("ungap_map4", 32'(arch_map[4]), 43);
    chk("ungap_map6", 32'(arch_map[6]), 45);

    // Same-cycle WAW on areg 7; slot 2 targets areg 0 with no Told
    set_slot(0, 1, 7, 50, 7); set_slot(1, 1, 7, 51, 50); set_slot(2, 1, 0, 60, 0);
    #1 chk("waw_rnum", 32'(retire_num), 3);
    step(); clear_in();
    chk("waw_map7", 32'(arch_map[7]), 51);
    chk("waw_map0", 32'(arch_map[0]), 0);
    chk_told("waw", 7, 50, 0);

    // Mispredict in slot 1 truncates and flushes
    set_slot(0, 1, 8, 52, 8); set_slot(1, 1, 9, 53, 9); set_slot(2, 1, 10, 54, 10);
    head_mispredict[1] = 1'b1;
    #1 chk("mis_rnum", 32'(retire_num), 2);
    step();
    chk("mis_flush", 32'(flush), 1);
    chk("mis_flush_rnum", 32'(retire_num), 0);
    chk("mis_map8", 32'(arch_map[8]), 52);
    chk("mis_map9", 32'(arch_map[9]), 53);
    chk("mis_map10", 32'(arch_map[10]), 10);
    chk_told("mis", 8, 9, 0);
    step();
    chk("post_flush", 32'(flush), 0);
    chk_told("post_flush", 0, 0, 0);
    head_mispredict = '0;
    #1 chk("resume_rnum", 32'(retire_num), 3);
    clear_in();

    // Halt and mispredict on the same slot: halt wins
    set_slot(0, 1, 11, 55, 11); set_slot(1, 1, 12, 56, 12); set_slot(2, 1, 13, 57, 13);
    head_halt[0] = 1'b1; head_mispredict[0] = 1'b1;
    #1 chk("halt_rnum", 32'(retire_num), 1);
    step();
    chk("halt_halted", 32'(halted), 1);
    chk("halt_noflush", 32'(flush), 0);
    chk("halt_rnum0", 32'(retire_num), 0);
    chk("halt_map11", 32'(arch_map[11]), 55);
    chk("halt_map12", 32'(arch_map[12]), 12);
    chk_told("halt", 11, 0, 0);
    step(); step();
    chk("halt_sticky", 32'(halted), 1);
    chk_told("halt_idle", 0, 0, 0);

    // Async reset while halted restores RUN and identity map
    #2 reset = 1'b1;
    #1;
    chk("rst2_halted", 32'(halted), 0);
    chk("rst2_map1", 32'(arch_map[1]), 1);
    chk("rst2_map11", 32'(arch_map[11]), 11);
    step();
    reset = 1'b0;
    head_halt = '0; head_mispredict = '0;
    #1 chk("rst2_rnum", 32'(retire_num), 3);
    clear_in();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
